// File: rtl/avalon_protocol_monitor_if.sv
// Avalon-MM bus bundle with views for the master, the slave and a passive monitor.
interface avalon_protocol_monitor_if #(
  parameter int unsigned NBDATABYTES = 2,
  parameter int unsigned NBADDRBITS  = 8
);
  localparam int unsigned DW = 8 * NBDATABYTES;

  logic [NBADDRBITS-1:0]  address;
  logic [NBDATABYTES-1:0] byteenable;
  logic [DW-1:0]          readdata;
  logic [DW-1:0]          writedata;
  logic                   read;
  logic                   write;
  logic                   waitrequest;
  logic                   readdatavalid;
  logic [7:0]             burstcount;
  logic                   beginbursttransfer;

  modport master (
    output address, byteenable, writedata, read, write, burstcount, beginbursttransfer,
    input  readdata, waitrequest, readdatavalid
  );

  modport slave (
    input  address, byteenable, writedata, read, write, burstcount, beginbursttransfer,
    output readdata, waitrequest, readdatavalid
  );

  // Read-only view; read data content is not checked so it is not part of it.
  modport monitor (
    input address, byteenable, writedata, read, write, waitrequest, readdatavalid,
          burstcount, beginbursttransfer
  );
endinterface

// File: rtl/avalon_protocol_monitor.sv
// Passive Avalon-MM protocol monitor: sticky per-rule error flags, saturating error
// count, outstanding-read tracking, burst sequencing and traffic counters.
module avalon_protocol_monitor #(
  parameter int unsigned AVALONMODE  = 0,
  parameter int unsigned NBDATABYTES = 2,
  parameter int unsigned NBADDRBITS  = 8,
  parameter int unsigned READDELAY   = 1,
  parameter int unsigned MAXPENDING  = 8,
  parameter int unsigned ERRCNTWIDTH = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  avalon_protocol_monitor_if.monitor         bus,
  input  logic                               clear,
  output logic [4:0]                         err_vec,
  output logic [ERRCNTWIDTH-1:0]             err_count,
  output logic [$clog2(MAXPENDING+1)-1:0]    pending,
  output logic [15:0]                        rd_beats,
  output logic [15:0]                        wr_beats
);
  localparam int unsigned DW  = 8 * NBDATABYTES;
  localparam int unsigned PW  = $clog2(MAXPENDING + 1);
  localparam int unsigned SW  = PW + 9;
  localparam int unsigned RDW = (READDELAY < 1) ? 1 : READDELAY;

  localparam bit MODE_FIXED = (AVALONMODE == 1);
  localparam bit MODE_PIPE  = (AVALONMODE >= 2);
  localparam bit MODE_BURST = (AVALONMODE == 3);

  localparam logic [0:0] ST_IDLE     = 1'b0;
  localparam logic [0:0] ST_WR_BURST = 1'b1;

  logic [0:0]             state_q, state_d;
  logic [7:0]             beats_left_q, beats_left_d;
  logic [7:0]             orig_bc_q, orig_bc_d;
  logic                   stalled_q, stalled_d;
  logic                   cap_read_q, cap_read_d;
  logic                   cap_write_q, cap_write_d;
  logic [NBADDRBITS-1:0]  cap_addr_q, cap_addr_d;
  logic [NBDATABYTES-1:0] cap_be_q, cap_be_d;
  logic [DW-1:0]          cap_wdata_q, cap_wdata_d;
  logic [7:0]             cap_bc_q, cap_bc_d;
  logic [RDW-1:0]         pipe_q, pipe_d;
  logic [PW-1:0]          pending_q, pending_d;
  logic [4:0]             err_vec_q, err_vec_d;
  logic [ERRCNTWIDTH-1:0] err_count_q, err_count_d;
  logic [15:0]            rd_beats_q, rd_beats_d;
  logic [15:0]            wr_beats_q, wr_beats_d;

  logic                   cmd, conflict, stall, acc, rd_acc, wr_acc;
  logic [7:0]             eff_bc;
  logic [4:0]             new_err;
  logic                   rd_valid;
  logic                   dec;
  logic [7:0]             inc;
  logic [SW-1:0]          nxt;

  // A cycle with both read and write is a protocol error, never an accept.
  assign cmd      = bus.read | bus.write;
  assign conflict = bus.read & bus.write;
  assign stall    = cmd & bus.waitrequest;
  assign acc      = cmd & ~bus.waitrequest & ~conflict;
  assign rd_acc   = acc & bus.read;
  assign wr_acc   = acc & bus.write;
  assign eff_bc   = (bus.burstcount == 8'd0) ? 8'd1 : bus.burstcount;

  always_comb begin
    state_d      = state_q;
    beats_left_d = beats_left_q;
    orig_bc_d    = orig_bc_q;
    stalled_d    = stall;
    cap_read_d   = cap_read_q;
    cap_write_d  = cap_write_q;
    cap_addr_d   = cap_addr_q;
    cap_be_d     = cap_be_q;
    cap_wdata_d  = cap_wdata_q;
    cap_bc_d     = cap_bc_q;
    pipe_d       = '0;
    pending_d    = '0;
    err_vec_d    = err_vec_q;
    err_count_d  = err_count_q;
    rd_beats_d   = rd_beats_q;
    wr_beats_d   = wr_beats_q;
    new_err      = '0;
    rd_valid     = 1'b0;
    dec          = 1'b0;
    inc          = 8'd0;
    nxt          = '0;

    new_err[0] = conflict;

    // Stability: a stalled command must be presented unchanged on the following cycle.
    if (stall) begin
      cap_read_d  = bus.read;
      cap_write_d = bus.write;
      cap_addr_d  = bus.address;
      cap_be_d    = bus.byteenable;
      cap_wdata_d = bus.writedata;
      cap_bc_d    = bus.burstcount;
    end
    if (stalled_q) begin
      if ((bus.read != cap_read_q) || (bus.write != cap_write_q) ||
          (bus.address != cap_addr_q) || (bus.byteenable != cap_be_q) ||
          (bus.writedata != cap_wdata_q) ||
          (MODE_BURST && (bus.burstcount != cap_bc_q))) begin
        new_err[1] = 1'b1;
      end
    end

    // Read return checking: fixed-latency pipe, or outstanding-beat counter.
    if (MODE_FIXED) begin
      pipe_d[0] = rd_acc;
      for (int i = 1; i < int'(RDW); i++) begin
        pipe_d[i] = pipe_q[i-1];
      end
      if (bus.readdatavalid != pipe_q[RDW-1]) new_err[2] = 1'b1;
      rd_valid = bus.readdatavalid & pipe_q[RDW-1];
    end else if (MODE_PIPE) begin
      dec      = bus.readdatavalid && (pending_q != '0);
      rd_valid = dec;
      if (bus.readdatavalid && (pending_q == '0)) new_err[2] = 1'b1;
      if (rd_acc) inc = MODE_BURST ? eff_bc : 8'd1;
      nxt = SW'(pending_q) + SW'(inc) - SW'(dec);
      if (nxt > SW'(MAXPENDING)) begin
        new_err[3] = 1'b1;
        pending_d  = PW'(MAXPENDING);
      end else begin
        pending_d  = PW'(nxt);
      end
    end else begin
      rd_valid = rd_acc;
    end

    // Burst sequencing; only write bursts span several command cycles.
    if (MODE_BURST) begin
      case (state_q)
        ST_IDLE: begin
          if (cmd && !stalled_q && !bus.beginbursttransfer) new_err[4] = 1'b1;
          if (bus.beginbursttransfer && !cmd) new_err[4] = 1'b1;
          if (acc && (bus.burstcount == 8'd0)) new_err[4] = 1'b1;
          if (wr_acc && (eff_bc > 8'd1)) begin
            beats_left_d = eff_bc - 8'd1;
            orig_bc_d    = bus.burstcount;
            state_d      = ST_WR_BURST;
          end
        end
        ST_WR_BURST: begin
          if (bus.read || bus.beginbursttransfer) begin
            new_err[4]   = 1'b1;
            beats_left_d = 8'd0;
            state_d      = ST_IDLE;
          end else begin
            if (bus.write && (bus.burstcount != orig_bc_q)) new_err[4] = 1'b1;
            if (wr_acc) begin
              beats_left_d = beats_left_q - 8'd1;
              if (beats_left_q == 8'd1) state_d = ST_IDLE;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    wr_beats_d = wr_beats_q + 16'(wr_acc);
    rd_beats_d = rd_beats_q + 16'(rd_valid);

    // Clear wins over anything detected in the same cycle.
    if (clear) begin
      err_vec_d   = '0;
      err_count_d = '0;
    end else begin
      err_vec_d = err_vec_q | new_err;
      if ((new_err != '0) && (err_count_q != '1)) begin
        err_count_d = err_count_q + ERRCNTWIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      beats_left_q <= '0;
      orig_bc_q    <= '0;
      stalled_q    <= 1'b0;
      cap_read_q   <= 1'b0;
      cap_write_q  <= 1'b0;
      cap_addr_q   <= '0;
      cap_be_q     <= '0;
      cap_wdata_q  <= '0;
      cap_bc_q     <= '0;
      pipe_q       <= '0;
      pending_q    <= '0;
      err_vec_q    <= '0;
      err_count_q  <= '0;
      rd_beats_q   <= '0;
      wr_beats_q   <= '0;
    end else begin
      state_q      <= state_d;
      beats_left_q <= beats_left_d;
      orig_bc_q    <= orig_bc_d;
      stalled_q    <= stalled_d;
      cap_read_q   <= cap_read_d;
      cap_write_q  <= cap_write_d;
      cap_addr_q   <= cap_addr_d;
      cap_be_q     <= cap_be_d;
      cap_wdata_q  <= cap_wdata_d;
      cap_bc_q     <= cap_bc_d;
      pipe_q       <= pipe_d;
      pending_q    <= pending_d;
      err_vec_q    <= err_vec_d;
      err_count_q  <= err_count_d;
      rd_beats_q   <= rd_beats_d;
      wr_beats_q   <= wr_beats_d;
    end
  end

  assign err_vec   = err_vec_q;
  assign err_count = err_count_q;
  assign pending   = pending_q;
  assign rd_beats  = rd_beats_q;
  assign wr_beats  = wr_beats_q;
endmodule

// File: tb/tb_avalon_protocol_monitor.sv
// Scoreboard bench for avalon_protocol_monitor: one shared bus stimulus feeds four
// monitors (modes 0..3); expected output snapshots are queued and compared after each edge.
module tb_avalon_protocol_monitor;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clear = 1'b0;
  logic [7:0]  address = '0;
  logic [1:0]  byteenable = '0;
  logic [15:0] readdata = '0;
  logic [15:0] writedata = '0;
  logic        read = 1'b0, write = 1'b0, waitrequest = 1'b0, readdatavalid = 1'b0;
  logic [7:0]  burstcount = 8'd1;
  logic        bbt = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  avalon_protocol_monitor_if bus0 ();
  avalon_protocol_monitor_if bus1 ();
  avalon_protocol_monitor_if bus2 ();
  avalon_protocol_monitor_if bus3 ();

  assign bus0.address = address;  assign bus0.byteenable = byteenable;
  assign bus0.readdata = readdata; assign bus0.writedata = writedata;
  assign bus0.read = read; assign bus0.write = write; assign bus0.waitrequest = waitrequest;
  assign bus0.readdatavalid = readdatavalid; assign bus0.burstcount = burstcount;
  assign bus0.beginbursttransfer = bbt;
  assign bus1.address = address;  assign bus1.byteenable = byteenable;
  assign bus1.readdata = readdata; assign bus1.writedata = writedata;
  assign bus1.read = read; assign bus1.write = write; assign bus1.waitrequest = waitrequest;
  assign bus1.readdatavalid = readdatavalid; assign bus1.burstcount = burstcount;
  assign bus1.beginbursttransfer = bbt;
  assign bus2.address = address;  assign bus2.byteenable = byteenable;
  assign bus2.readdata = readdata; assign bus2.writedata = writedata;
  assign bus2.read = read; assign bus2.write = write; assign bus2.waitrequest = waitrequest;
  assign bus2.readdatavalid = readdatavalid; assign bus2.burstcount = burstcount;
  assign bus2.beginbursttransfer = bbt;
  assign bus3.address = address;  assign bus3.byteenable = byteenable;
  assign bus3.readdata = readdata; assign bus3.writedata = writedata;
  assign bus3.read = read; assign bus3.write = write; assign bus3.waitrequest = waitrequest;
  assign bus3.readdatavalid = readdatavalid; assign bus3.burstcount = burstcount;
  assign bus3.beginbursttransfer = bbt;

  logic [4:0]  ev_w [4];
  logic [7:0]  ec_w [4];
  logic [15:0] rb_w [4];
  logic [15:0] wb_w [4];
  logic [3:0]  p0, p1, p3;
  logic [2:0]  p2;

  avalon_protocol_monitor #(.AVALONMODE(0)) u_m0 (
    .clk(clk), .rst(rst), .bus(bus0), .clear(clear), .err_vec(ev_w[0]), .err_count(ec_w[0]),
    .pending(p0), .rd_beats(rb_w[0]), .wr_beats(wb_w[0]));
  avalon_protocol_monitor #(.AVALONMODE(1), .READDELAY(2)) u_m1 (
    .clk(clk), .rst(rst), .bus(bus1), .clear(clear), .err_vec(ev_w[1]), .err_count(ec_w[1]),
    .pending(p1), .rd_beats(rb_w[1]), .wr_beats(wb_w[1]));
  avalon_protocol_monitor #(.AVALONMODE(2), .MAXPENDING(4)) u_m2 (
    .clk(clk), .rst(rst), .bus(bus2), .clear(clear), .err_vec(ev_w[2]), .err_count(ec_w[2]),
    .pending(p2), .rd_beats(rb_w[2]), .wr_beats(wb_w[2]));
  avalon_protocol_monitor #(.AVALONMODE(3)) u_m3 (
    .clk(clk), .rst(rst), .bus(bus3), .clear(clear), .err_vec(ev_w[3]), .err_count(ec_w[3]),
    .pending(p3), .rd_beats(rb_w[3]), .wr_beats(wb_w[3]));

  typedef struct {
    string       tag;
    int          dut;
    logic [4:0]  ev;
    logic [7:0]  ec;
    logic [3:0]  pd;
    logic [15:0] rb;
    logic [15:0] wb;
  } exp_t;

  exp_t sb[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] pend_of(input int d);
    case (d)
      0:       return p0;
      1:       return p1;
      2:       return {1'b0, p2};
      default: return p3;
    endcase
  endfunction

  task automatic expect_st(input string tag, input int d, input logic [4:0] ev,
                           input logic [7:0] ec, input logic [3:0] pd,
                           input logic [15:0] rb, input logic [15:0] wb);
    exp_t e;
    e.tag = tag; e.dut = d; e.ev = ev; e.ec = ec; e.pd = pd; e.rb = rb; e.wb = wb;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() != 0) begin
      e = sb.pop_front();
      check_eq({e.tag, ".err_vec"},   32'(ev_w[e.dut]),    32'(e.ev));
      check_eq({e.tag, ".err_count"}, 32'(ec_w[e.dut]),    32'(e.ec));
      check_eq({e.tag, ".pending"},   32'(pend_of(e.dut)), 32'(e.pd));
      check_eq({e.tag, ".rd_beats"},  32'(rb_w[e.dut]),    32'(e.rb));
      check_eq({e.tag, ".wr_beats"},  32'(wb_w[e.dut]),    32'(e.wb));
    end
  endtask

  // One clock edge, then compare everything queued for it.
  task automatic step();
    @(posedge clk);
    #1;
    drain();
  endtask

  task automatic bus_set(input logic rd, input logic wr, input logic wt, input logic rdv,
                         input logic bb, input logic [7:0] bc);
    read = rd; write = wr; waitrequest = wt; readdatavalid = rdv; bbt = bb; burstcount = bc;
  endtask

  task automatic do_reset();
    bus_set(0, 0, 0, 0, 0, 8'd1);
    clear = 1'b0;
    rst = 1'b0;
    #2;
    for (int d = 0; d < 4; d++) expect_st("reset", d, 5'd0, 8'd0, 4'd0, 16'd0, 16'd0);
    drain();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #3;
    do_reset();

    // Mode 0: address moves during a stalled write.
    address = 8'h12; writedata = 16'hBEEF; byteenable = 2'b11;
    bus_set(0, 1, 1, 0, 0, 8'd1);
    expect_st("m0_stall_a", 0, 5'b00000, 8'd0, 4'd0, 16'd0, 16'd0); step();
    address = 8'h13;
    expect_st("m0_stall_b", 0, 5'b00010, 8'd1, 4'd0, 16'd0, 16'd0); step();
    waitrequest = 1'b0;
    expect_st("m0_accept", 0, 5'b00010, 8'd1, 4'd0, 16'd0, 16'd1); step();
    bus_set(0, 0, 0, 0, 0, 8'd1);
    expect_st("m0_idle", 0, 5'b00010, 8'd1, 4'd0, 16'd0, 16'd1); step();
    clear = 1'b1;
    expect_st("m0_clear", 0, 5'b00000, 8'd0, 4'd0, 16'd0, 16'd1); step();
    clear = 1'b0;

    // read and write together, then clear (also clear racing a new error).
    do_reset();
    bus_set(1, 1, 0, 0, 0, 8'd1);
    expect_st("rw_both", 0, 5'b00001, 8'd1, 4'd0, 16'd0, 16'd0); step();
    bus_set(0, 0, 0, 0, 0, 8'd1);
    expect_st("rw_sticky", 0, 5'b00001, 8'd1, 4'd0, 16'd0, 16'd0); step();
    clear = 1'b1;
    expect_st("rw_clear", 0, 5'b00000, 8'd0, 4'd0, 16'd0, 16'd0); step();
    bus_set(1, 1, 0, 0, 0, 8'd1);
    expect_st("rw_clear_prio", 0, 5'b00000, 8'd0, 4'd0, 16'd0, 16'd0); step();
    clear = 1'b0;
    bus_set(0, 0, 0, 0, 0, 8'd1);
    step();

    // Mode 1, READDELAY=2: valid returns once on time, once late.
    do_reset();
    bus_set(1, 0, 0, 0, 0, 8'd1);
    expect_st("m1_c0", 1, 5'b00000, 8'd0, 4'd0, 16'd0, 16'd0); step();
    expect_st("m1_c1", 1, 5'b00000, 8'd0, 4'd0, 16'd0, 16'd0); step();
    bus_set(0, 0, 0, 1, 0, 8'd1);
    expect_st("m1_c2", 1, 5'b00000, 8'd0, 4'd0, 16'd1, 16'd0); step();
    bus_set(0, 0, 0, 0, 0, 8'd1);
    expect_st("m1_c3", 1, 5'b00100, 8'd1, 4'd0, 16'd1, 16'd0); step();
    bus_set(0, 0, 0, 1, 0, 8'd1);
    expect_st("m1_c4", 1, 5'b00100, 8'd2, 4'd0, 16'd1, 16'd0); step();
    bus_set(0, 0, 0, 0, 0, 8'd1);
    expect_st("m1_c5", 1, 5'b00100, 8'd2, 4'd0, 16'd1, 16'd0); step();

    // Mode 2, MAXPENDING=4: overflow then drain past empty.
    do_reset();
    bus_set(1, 0, 0, 0, 0, 8'd1);
    for (int i = 1; i <= 4; i++) begin
      expect_st($sformatf("m2_rd%0d", i), 2, 5'b00000, 8'd0, 4'(i), 16'd0, 16'd0); step();
    end
    expect_st("m2_rd5", 2, 5'b01000, 8'd1, 4'd4, 16'd0, 16'd0); step();
    bus_set(0, 0, 0, 1, 0, 8'd1);
    for (int i = 1; i <= 4; i++) begin
      expect_st($sformatf("m2_rdv%0d", i), 2, 5'b01000, 8'd1, 4'(4 - i), 16'(i), 16'd0); step();
    end
    expect_st("m2_rdv5", 2, 5'b01100, 8'd2, 4'd0, 16'd4, 16'd0); step();
    bus_set(0, 0, 0, 0, 0, 8'd1);
    step();

    // Mode 3: clean 4-beat write burst with a stall on beat 2.
    do_reset();
    bus_set(0, 1, 0, 0, 1, 8'd4);
    expect_st("m3_b1", 3, 5'b00000, 8'd0, 4'd0, 16'd0, 16'd1); step();
    bus_set(0, 1, 1, 0, 0, 8'd4);
    expect_st("m3_b2_stall", 3, 5'b00000, 8'd0, 4'd0, 16'd0, 16'd1); step();
    bus_set(0, 1, 0, 0, 0, 8'd4);
    expect_st("m3_b2", 3, 5'b00000, 8'd0, 4'd0, 16'd0, 16'd2); step();
    expect_st("m3_b3", 3, 5'b00000, 8'd0, 4'd0, 16'd0, 16'd3); step();
    expect_st("m3_b4", 3, 5'b00000, 8'd0, 4'd0, 16'd0, 16'd4); step();
    bus_set(0, 0, 0, 0, 0, 8'd1);
    expect_st("m3_idle", 3, 5'b00000, 8'd0, 4'd0, 16'd0, 16'd4); step();
    // Second burst interrupted by a read after two beats.
    bus_set(0, 1, 0, 0, 1, 8'd4);
    expect_st("m3_r_b1", 3, 5'b00000, 8'd0, 4'd0, 16'd0, 16'd5); step();
    bus_set(0, 1, 0, 0, 0, 8'd4);
    expect_st("m3_r_b2", 3, 5'b00000, 8'd0, 4'd0, 16'd0, 16'd6); step();
    bus_set(1, 0, 0, 0, 1, 8'd1);
    expect_st("m3_rd_in_burst", 3, 5'b10000, 8'd1, 4'd1, 16'd0, 16'd6); step();
    // Back in IDLE: a fresh single write with beginbursttransfer is legal.
    bus_set(0, 1, 0, 0, 1, 8'd1);
    expect_st("m3_idle_wr", 3, 5'b10000, 8'd1, 4'd1, 16'd0, 16'd7); step();
    bus_set(0, 0, 0, 1, 0, 8'd1);
    expect_st("m3_rdv", 3, 5'b10000, 8'd1, 4'd0, 16'd1, 16'd7); step();
    bus_set(0, 1, 0, 0, 1, 8'd0);
    expect_st("m3_bc0", 3, 5'b10000, 8'd2, 4'd0, 16'd1, 16'd8); step();
    bus_set(0, 0, 0, 0, 1, 8'd1);
    expect_st("m3_bbt_nocmd", 3, 5'b10000, 8'd3, 4'd0, 16'd1, 16'd8); step();
    bus_set(0, 1, 0, 0, 0, 8'd1);
    expect_st("m3_no_bbt", 3, 5'b10000, 8'd4, 4'd0, 16'd1, 16'd9); step();
    bus_set(0, 0, 0, 0, 0, 8'd1);
    step();

    // Mode 3: reset with a read burst outstanding.
    do_reset();
    bus_set(1, 0, 0, 0, 1, 8'd3);
    expect_st("m3_rst_rd", 3, 5'b00000, 8'd0, 4'd3, 16'd0, 16'd0); step();
    bus_set(0, 0, 0, 1, 0, 8'd1);
    expect_st("m3_rst_rdv", 3, 5'b00000, 8'd0, 4'd2, 16'd1, 16'd0); step();
    bus_set(0, 0, 0, 0, 0, 8'd1);
    #2;
    rst = 1'b0;
    #1;
    expect_st("m3_rst_async", 3, 5'b00000, 8'd0, 4'd0, 16'd0, 16'd0); drain();
    @(posedge clk);
    #1;
    rst = 1'b1;
    expect_st("m3_rst_after", 3, 5'b00000, 8'd0, 4'd0, 16'd0, 16'd0); step();
    expect_st("m3_rst_after2", 3, 5'b00000, 8'd0, 4'd0, 16'd0, 16'd0); step();

    // err_count saturation under a continuous error.
    do_reset();
    bus_set(1, 1, 0, 0, 0, 8'd1);
    repeat (260) @(posedge clk);
    #1;
    expect_st("m0_sat", 0, 5'b00001, 8'd255, 4'd0, 16'd0, 16'd0); drain();
    bus_set(0, 0, 0, 0, 0, 8'd1);
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
